// File: rtl/nn_layer_sequencer.sv
// nn_layer_sequencer
// Initiator for one fully-connected layer built from N_OUT parallel MAC
// neurons. Streams the input vector (and, via the shared read address, the
// weight rows) into the neurons, keeps Active asserted while the MAC
// pipeline drains, then serialises the held Z outputs into a result RAM.
//
// Build option: define NN_SEQ_RELU_EN to apply ReLU to each result on
// write-back (hidden layers). Leave it undefined for the output layer so
// the raw scores reach the arg-max stage. Timing is identical either way.
//
// All outputs are decoded combinationally from the state register and the
// step counter, so an asynchronous reset forces every output to zero in
// the same cycle it is asserted.

module nn_layer_sequencer #(
    parameter int N_IN    = 784,
    parameter int N_OUT   = 20,
    parameter int MAC_LAT = 3,
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [DATA_W-1:0] i_rd_data,
    output logic [DATA_W-1:0] o_x,
    output logic              o_active,
    output logic [ADDR_W-1:0] o_z_sel,
    input  logic [DATA_W-1:0] i_z_in,
    output logic              o_y_we,
    output logic [ADDR_W-1:0] o_y_addr,
    output logic [DATA_W-1:0] o_y_data
);

    // Step counter must reach N_IN (last FEED cycle) and must be at least
    // ADDR_W wide so the address outputs are a plain slice of it.
    localparam int CNT_RAW = $clog2(N_IN + MAC_LAT + N_OUT + 2) + 1;
    localparam int CNT_W   = (ADDR_W > CNT_RAW) ? ADDR_W : CNT_RAW;

    // Last counter value of each timed state.
    localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(N_IN);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(MAC_LAT);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] RD_LIMIT   = CNT_W'(N_IN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FEED  = 3'd1,
        S_DRAIN = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_relu_neg;
    logic [DATA_W-1:0]  w_f_z;

    // ------------------------------------------------------------------
    // Write-back transfer function f(z)
    // ------------------------------------------------------------------
`ifdef NN_SEQ_RELU_EN
    // Negative Q4.11 results are clamped to zero.
    assign w_relu_neg = i_z_in[DATA_W-1];
`else
    // Raw scores pass through untouched.
    assign w_relu_neg = 1'b0;
`endif

    // Per-bit mask: every bit is cleared when the value is to be zeroed.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_relu_mask
            assign w_f_z[gi] = i_z_in[gi] & ~w_relu_neg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------

    // State register and step counter; counter restarts on every state entry.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Next-state decode; Start is only looked at in IDLE.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_next = S_FEED;
                end
            end
            S_FEED: begin
                if (r_cnt == FEED_LAST) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_cnt == WRITE_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Output decode from state and counter.
    always_comb begin
        o_busy    = (r_state != S_IDLE);
        o_done    = 1'b0;
        o_rd_en   = 1'b0;
        o_rd_addr = '0;
        o_x       = '0;
        o_active  = 1'b0;
        o_z_sel   = '0;
        o_y_we    = 1'b0;
        o_y_addr  = '0;
        o_y_data  = '0;
        case (r_state)
            S_FEED: begin
                // Read k while k < N_IN; its data lands one cycle later,
                // which is why Active starts at cnt=1. The cnt=0 cycle with
                // Active low clears the accumulators before the first product.
                if (r_cnt < RD_LIMIT) begin
                    o_rd_en   = 1'b1;
                    o_rd_addr = r_cnt[ADDR_W-1:0];
                end
                if (r_cnt != '0) begin
                    o_active = 1'b1;
                    o_x      = i_rd_data;
                end
            end
            S_DRAIN: begin
                // Zero products only, while the last real products work
                // through the MAC pipeline and land in Z.
                o_active = 1'b1;
            end
            S_WRITE: begin
                // Active low: neurons hold Z. Walk the Z mux one neuron per cycle.
                o_z_sel  = r_cnt[ADDR_W-1:0];
                o_y_we   = 1'b1;
                o_y_addr = r_cnt[ADDR_W-1:0];
                o_y_data = w_f_z;
            end
            S_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed bench for nn_layer_sequencer with a small layer
// (N_IN=4, N_OUT=2, MAC_LAT=3). Input RAM holds {1,2,3,4}; the Z mux
// returns 0x0800 for neuron 0 and 0xF800 for neuron 1.
// Cycle numbering: cycle 1 is the cycle after the edge that samples Start.

module tb_nn_layer_sequencer;

    localparam int N_IN    = 4;
    localparam int N_OUT   = 2;
    localparam int MAC_LAT = 3;
    localparam int ADDR_W  = 10;
    localparam int DATA_W  = 16;

`ifdef NN_SEQ_RELU_EN
    localparam logic [15:0] EXP_Y1 = 16'h0000;
`else
    localparam logic [15:0] EXP_Y1 = 16'hF800;
`endif
    localparam logic [15:0] EXP_Y0 = 16'h0800;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, done, rd_en, active, y_we;
    logic [ADDR_W-1:0] rd_addr, z_sel, y_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] x, z_in, y_data;

    logic [DATA_W-1:0] in_mem [4];
    logic [DATA_W-1:0] y_mem  [4];

    int n_cmp = 0;
    int n_err = 0;

    nn_layer_sequencer #(
        .N_IN(N_IN), .N_OUT(N_OUT), .MAC_LAT(MAC_LAT),
        .ADDR_W(ADDR_W), .DATA_W(DATA_W)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_start(start),
        .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_data(rd_data),
        .o_x(x), .o_active(active),
        .o_z_sel(z_sel), .i_z_in(z_in),
        .o_y_we(y_we), .o_y_addr(y_addr), .o_y_data(y_data)
    );

    always #5 clk = ~clk;

    // Synchronous input RAM: data valid the cycle after the read strobe.
    always @(posedge clk) if (rd_en) rd_data <= in_mem[rd_addr[1:0]];

    // Neuron bank stand-in: held Z values behind a combinational mux.
    always_comb z_in = (z_sel == '0) ? 16'h0800 : 16'hF800;

    // Result RAM capture.
    always @(posedge clk) if (y_we) y_mem[y_addr[1:0]] <= y_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
            $error("check %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"},    32'(busy),    32'd0);
        chk({tag, " done"},    32'(done),    32'd0);
        chk({tag, " rd_en"},   32'(rd_en),   32'd0);
        chk({tag, " active"},  32'(active),  32'd0);
        chk({tag, " y_we"},    32'(y_we),    32'd0);
        chk({tag, " x"},       32'(x),       32'd0);
        chk({tag, " rd_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, " z_sel"},   32'(z_sel),   32'd0);
        chk({tag, " y_addr"},  32'(y_addr),  32'd0);
        chk({tag, " y_data"},  32'(y_data),  32'd0);
    endtask

    // Full run check; caller has Start=1 set at a negedge. Start is raised
    // again for one cycle at cycle pulse_at (0 = never).
    task automatic run_check(input string name, input int pulse_at);
        logic [31:0] e_rd_en, e_rd_addr, e_act, e_x, e_we, e_ya, e_yd, e_done;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            e_rd_en   = (c >= 1 && c <= 4) ? 1 : 0;
            e_rd_addr = (c >= 1 && c <= 4) ? 32'(c - 1) : 0;
            e_act     = (c >= 2 && c <= 9) ? 1 : 0;
            e_x       = (c >= 2 && c <= 5) ? 32'(c - 1) : 0;
            e_we      = (c == 10 || c == 11) ? 1 : 0;
            e_ya      = (c == 11) ? 1 : 0;
            e_yd      = (c == 10) ? 32'(EXP_Y0) : (c == 11) ? 32'(EXP_Y1) : 0;
            e_done    = (c == 12) ? 1 : 0;
            chk($sformatf("%s busy@%0d", name, c),    32'(busy),    32'd1);
            chk($sformatf("%s rd_en@%0d", name, c),   32'(rd_en),   e_rd_en);
            chk($sformatf("%s rd_addr@%0d", name, c), 32'(rd_addr), e_rd_addr);
            chk($sformatf("%s active@%0d", name, c),  32'(active),  e_act);
            chk($sformatf("%s x@%0d", name, c),       32'(x),       e_x);
            chk($sformatf("%s y_we@%0d", name, c),    32'(y_we),    e_we);
            chk($sformatf("%s y_addr@%0d", name, c),  32'(y_addr),  e_ya);
            chk($sformatf("%s z_sel@%0d", name, c),   32'(z_sel),   e_ya);
            chk($sformatf("%s y_data@%0d", name, c),  32'(y_data),  e_yd);
            chk($sformatf("%s done@%0d", name, c),    32'(done),    e_done);
            start = (c == pulse_at);
        end
        start = 1'b0;
        // No second run may follow: stay idle for a while.
        for (int c = 13; c <= 20; c++) begin
            @(negedge clk);
            chk($sformatf("%s idle busy@%0d", name, c), 32'(busy), 32'd0);
            chk($sformatf("%s idle done@%0d", name, c), 32'(done), 32'd0);
        end
        chk({name, " ymem0"}, 32'(y_mem[0]), 32'(EXP_Y0));
        chk({name, " ymem1"}, 32'(y_mem[1]), 32'(EXP_Y1));
    endtask

    initial begin
        int first_done, second_done, fall, rise;
        logic act_hist [64];
        bit   idle_seen;

        in_mem[0] = 16'd1; in_mem[1] = 16'd2; in_mem[2] = 16'd3; in_mem[3] = 16'd4;
        for (int i = 0; i < 4; i++) y_mem[i] = 16'hDEAD;

        // Reset then idle.
        rst = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("in_reset");
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("idle busy@%0d", c),   32'(busy),   32'd0);
            chk($sformatf("idle active@%0d", c), 32'(active), 32'd0);
            chk($sformatf("idle rd_en@%0d", c),  32'(rd_en),  32'd0);
            chk($sformatf("idle y_we@%0d", c),   32'(y_we),   32'd0);
            chk($sformatf("idle done@%0d", c),   32'(done),   32'd0);
            chk($sformatf("idle x@%0d", c),      32'(x),      32'd0);
        end

        // Basic run with write-back.
        start = 1'b1;
        run_check("basic", 0);

        // Start pulsed during DRAIN (cycle 7) must be ignored.
        for (int i = 0; i < 4; i++) y_mem[i] = 16'hDEAD;
        start = 1'b1;
        run_check("ignore", 7);

        // Reset in the middle of FEED (cnt=2 is cycle 3).
        start = 1'b1;
        @(negedge clk);           // cycle 1
        start = 1'b0;
        @(negedge clk);           // cycle 2
        @(negedge clk);           // cycle 3
        chk("midfeed rd_addr", 32'(rd_addr), 32'd2);
        chk("midfeed active",  32'(active),  32'd1);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_reset");
        @(negedge clk);
        chk_all_zero("held_reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("after_reset");
        for (int i = 0; i < 4; i++) y_mem[i] = 16'hDEAD;
        start = 1'b1;
        run_check("post_reset", 0);

        // Back-to-back runs with Start held high.
        first_done = -1; second_done = -1; fall = -1; rise = -1;
        for (int i = 0; i < 64; i++) act_hist[i] = 1'b0;
        start = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            act_hist[c] = active;
            if (done) begin
                if (first_done < 0) first_done = c;
                else if (second_done < 0) second_done = c;
            end
        end
        start = 1'b0;
        for (int c = 2; c <= 40; c++) begin
            if (fall < 0 && act_hist[c-1] && !act_hist[c]) fall = c;
            else if (fall >= 0 && rise < 0 && !act_hist[c-1] && act_hist[c]) rise = c;
        end
        chk("b2b first_done",  32'(first_done),  32'd12);
        chk("b2b second_done", 32'(second_done), 32'd25);
        chk("b2b spacing",     32'(second_done - first_done), 32'd13);
        chk("b2b active_fall", 32'(fall), 32'd10);
        chk("b2b active_gap",  32'(rise - fall), 32'd5);

        // Let the run in flight finish, bounded.
        idle_seen = 1'b0;
        for (int c = 0; c < 30 && !idle_seen; c++) begin
            @(negedge clk);
            if (!busy) idle_seen = 1'b1;
        end
        chk("b2b returns_idle", 32'(idle_seen), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
